// File: rtl/div_share_pkg.sv
// rtl/div_share_pkg.sv - shared state encoding and width helpers for the divider arbiter
package div_share_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_FIX  = 2'd2;
  localparam state_t ST_RESP = 2'd3;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_nr_step.sv
// rtl/div_nr_step.sv - one combinational radix-2 non-restoring divide iteration
module div_nr_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH:0]   i_a,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH:0]   o_a,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH:0] w_a_sh;

  // Sign of the pre-shift A picks add/subtract; the shifted value may wrap, the sum cannot.
  assign w_a_sh = {i_a[WIDTH-1:0], i_q[WIDTH-1]};
  assign o_a    = i_a[WIDTH] ? (w_a_sh + {1'b0, i_d}) : (w_a_sh - {1'b0, i_d});
  assign o_q    = {i_q[WIDTH-2:0], ~o_a[WIDTH]};

endmodule

// File: rtl/div_share_arbiter.sv
// rtl/div_share_arbiter.sv - round-robin shared sequential divider; optional DIV_SHARE_DBZ_EN
module div_share_arbiter
  import div_share_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int NREQ  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WIDTH-1:0]    req_dividend,
  input  logic [NREQ*WIDTH-1:0]    req_divisor,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [WIDTH-1:0]         rsp_quotient,
  output logic [WIDTH-1:0]         rsp_remainder,
  output logic                     rsp_dbz,
  output logic                     busy
);

  localparam int ID_W  = id_w(NREQ);
  localparam int CNT_W = cnt_w(WIDTH);

  state_t           r_state;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_id;
  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [CNT_W-1:0] r_cnt;

  logic [NREQ-1:0]  w_rot;
  logic             w_hit;
  logic [ID_W-1:0]  w_off;
  logic [ID_W-1:0]  w_gid;
  logic [WIDTH-1:0] w_dvd;
  logic [WIDTH-1:0] w_dvs;
  logic [WIDTH:0]   w_a_n;
  logic [WIDTH-1:0] w_q_n;

  // Rotate so ptr+1 sits at bit 0, take the lowest valid, rotate the index back.
  always_comb begin
    int sum;
    w_rot = NREQ'({req_valid, req_valid} >> (int'(r_ptr) + 1));
    w_hit = 1'b0;
    w_off = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_hit = 1'b1;
        w_off = ID_W'(j);
      end
    end
    sum = int'(r_ptr) + 1 + int'(w_off);
    if (sum >= NREQ) sum = sum - NREQ;
    w_gid = ID_W'(sum);
  end

  assign w_dvd     = req_dividend[w_gid*WIDTH +: WIDTH];
  assign w_dvs     = req_divisor[w_gid*WIDTH +: WIDTH];
  assign req_ready = (r_state == ST_IDLE && w_hit) ? (NREQ'(1) << w_gid) : '0;

  div_nr_step #(.WIDTH(WIDTH)) u_step (
    .i_a (r_a),
    .i_q (r_q),
    .i_d (r_d),
    .o_a (w_a_n),
    .o_q (w_q_n)
  );

`ifdef DIV_SHARE_DBZ_EN
  logic r_dbz;
  assign rsp_dbz = r_dbz;
`else
  assign rsp_dbz = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= ID_W'(NREQ - 1);
      r_id    <= '0;
      r_a     <= '0;
      r_q     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
`ifdef DIV_SHARE_DBZ_EN
      r_dbz   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            r_id    <= w_gid;
            r_ptr   <= w_gid;
            r_d     <= w_dvs;
            r_a     <= '0;
            r_q     <= w_dvd;
            r_cnt   <= '0;
            r_state <= ST_RUN;
`ifdef DIV_SHARE_DBZ_EN
            r_dbz   <= (w_dvs == '0);
            if (w_dvs == '0) begin
              r_a     <= {1'b0, w_dvd};
              r_q     <= '1;
              r_state <= ST_RESP;
            end
`endif
          end
        end
        ST_RUN: begin
          r_a   <= w_a_n;
          r_q   <= w_q_n;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= ST_FIX;
        end
        ST_FIX: begin
          if (r_a[WIDTH]) r_a <= r_a + {1'b0, r_d};
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid     = (r_state == ST_RESP);
  assign rsp_id        = r_id;
  assign rsp_quotient  = r_q;
  assign rsp_remainder = r_a[WIDTH-1:0];
  assign busy          = (r_state != ST_IDLE);

endmodule
